hazard_controller: RTL and testbench

- Pipeline hazard and flush controller for the ARM 5-stage core.
- Keeps a shadow copy of the destination-register state of the EXE and MEM stages.
- Each cycle, compares the ID-stage source registers against that state and drives `hazard` (stall IF/ID, bubble into ID/EX) and `flush` (on a taken branch).
- Also holds the whole pipeline on `freeze`, and keeps saturating stall and flush performance counters.

---
 rtl/hazard_controller_pkg.sv | 22 ++
 rtl/hazard_sat_counter.sv | 18 +
 rtl/hazard_controller.sv | 85 ++++++++
 tb/tb_hazard_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the hazard controller: register address width,
// shadow-entry layout, the bubble constant and the destination-match helper.
package hazard_controller_pkg;

  localparam int REG_ADDRESS_LEN = 4;
  localparam int HZ_ENTRY_LEN    = 3 + REG_ADDRESS_LEN;

  typedef struct packed {
    logic                       v;
    logic                       wb_en;
    logic                       mem_read;
    logic [REG_ADDRESS_LEN-1:0] dest;
  } hz_entry_t;

  localparam hz_entry_t HZ_BUBBLE = hz_entry_t'({HZ_ENTRY_LEN{1'b0}});

  // A stage produces a value for r only if it holds a real, writing instruction.
  function automatic logic hz_match(input hz_entry_t e, input logic [REG_ADDRESS_LEN-1:0] r);
    return e.v & e.wb_en & (e.dest == r);
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (en && (count != {CNT_W{1'b1}}))
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush controller: shadows EXE and MEM destinations and flags RAW hazards
// against the ID-stage sources, with saturating stall and flush counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDRESS_LEN,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_uses_src1,
  input  logic                  id_two_src,
  input  logic                  id_wb_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_mem_read,
  input  logic                  exe_branch_taken,
  input  logic                  fwd_en,
  input  logic                  freeze,
  output logic                  hazard,
  output logic                  flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  hz_entry_t exe_q, mem_q;
  hz_entry_t exe_d, mem_d;
  logic      exe_hit, mem_hit, raw_hazard;

  assign exe_hit = (id_uses_src1 & hz_match(exe_q, id_src1)) |
                   (id_two_src   & hz_match(exe_q, id_src2));
  assign mem_hit = (id_uses_src1 & hz_match(mem_q, id_src1)) |
                   (id_two_src   & hz_match(mem_q, id_src2));

  // With forwarding only a load still in EXE cannot be bypassed in time.
  assign raw_hazard = id_valid & (fwd_en ? (exe_q.mem_read & exe_hit)
                                         : (exe_hit | mem_hit));

  // A taken branch makes the ID instruction wrong-path, so it never stalls.
  assign flush  = exe_branch_taken & ~freeze;
  assign hazard = raw_hazard & ~exe_branch_taken;

  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    if (!freeze) begin
      mem_d = exe_q;
      if (flush || hazard) begin
        exe_d = HZ_BUBBLE;
      end else begin
        exe_d.v        = id_valid;
        exe_d.wb_en    = id_wb_en & id_valid;
        exe_d.mem_read = id_mem_read & id_valid;
        exe_d.dest     = id_dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= HZ_BUBBLE;
      mem_q <= HZ_BUBBLE;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (hazard & ~freeze),
    .count (stall_count)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus randomized traffic checked
// against an in-flight instruction model; a CNT_W=4 copy exercises saturation.
module tb_hazard_controller;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_src1, id_src2, id_dest;
  logic        id_uses_src1, id_two_src, id_wb_en, id_mem_read;
  logic        exe_branch_taken, fwd_en, freeze;
  logic        hazard, flush, hazard4, flush4;
  logic [15:0] stall_count, flush_count;
  logic [3:0]  stall_count4, flush_count4;

  int checks = 0;
  int passes = 0;

  hazard_controller #(.REG_ADDR_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
    .id_dest(id_dest), .id_mem_read(id_mem_read), .exe_branch_taken(exe_branch_taken),
    .fwd_en(fwd_en), .freeze(freeze), .hazard(hazard), .flush(flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_controller #(.REG_ADDR_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
    .id_dest(id_dest), .id_mem_read(id_mem_read), .exe_branch_taken(exe_branch_taken),
    .fwd_en(fwd_en), .freeze(freeze), .hazard(hazard4), .flush(flush4),
    .stall_count(stall_count4), .flush_count(flush_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the instructions currently downstream of ID, index 0 = EXE, 1 = MEM.
  typedef struct {
    bit v;
    bit writes;
    bit load;
    int dest;
  } slot_t;

  slot_t pipe [2];
  int m_stall16, m_flush16, m_stall4, m_flush4;

  function automatic bit reads_reg(input int r);
    return (id_uses_src1 && int'(id_src1) == r) || (id_two_src && int'(id_src2) == r);
  endfunction

  function automatic bit exp_hazard();
    bit raw = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (pipe[s].v && pipe[s].writes && reads_reg(pipe[s].dest)) begin
        if (!fwd_en || (s == 0 && pipe[s].load)) raw = 1'b1;
      end
    end
    return id_valid && raw && !exe_branch_taken;
  endfunction

  function automatic bit exp_flush();
    return exe_branch_taken && !freeze;
  endfunction

  // Advance the model by one clock using the currently driven inputs, then let the DUT edge happen.
  task automatic tick();
    bit    h, f;
    slot_t empty_slot;
    empty_slot = '{v: 1'b0, writes: 1'b0, load: 1'b0, dest: 0};
    h = exp_hazard();
    f = exp_flush();
    if (rst) begin
      pipe[0] = empty_slot;
      pipe[1] = empty_slot;
      m_stall16 = 0; m_flush16 = 0; m_stall4 = 0; m_flush4 = 0;
    end else if (!freeze) begin
      pipe[1] = pipe[0];
      if (h || f)
        pipe[0] = empty_slot;
      else
        pipe[0] = '{v: id_valid, writes: id_wb_en && id_valid, load: id_mem_read && id_valid,
                    dest: int'(id_dest)};
      if (h) begin
        if (m_stall16 < 65535) m_stall16++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (f) begin
        if (m_flush16 < 65535) m_flush16++;
        if (m_flush4 < 15) m_flush4++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_uses_src1 = 0; id_two_src = 0;
    id_wb_en = 0; id_dest = 0; id_mem_read = 0; exe_branch_taken = 0; freeze = 0;
  endtask

  task automatic set_instr(input int s1, input int s2, input bit two, input int d, input bit ld);
    id_valid = 1; id_uses_src1 = 1; id_src1 = 4'(s1); id_src2 = 4'(s2); id_two_src = two;
    id_wb_en = 1; id_dest = 4'(d); id_mem_read = ld;
  endtask

  task automatic do_reset();
    rst = 1;
    set_idle();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    fwd_en = 0;
    do_reset();
    checks++; if (hazard !== 1'b0) $display("[TB] FAIL reset_hazard: got %b expected 0", hazard); else passes++;
    checks++; if (flush !== 1'b0) $display("[TB] FAIL reset_flush: got %b expected 0", flush); else passes++;
    checks++; if (stall_count !== 16'd0) $display("[TB] FAIL reset_stall_count: got %0d expected 0", stall_count); else passes++;
    checks++; if (flush_count !== 16'd0) $display("[TB] FAIL reset_flush_count: got %0d expected 0", flush_count); else passes++;
    tick();
    // Empty shadow: even a register-0 reader must not stall.
    set_instr(0, 0, 1, 0, 0);
    #1;
    checks++; if (hazard !== 1'b0) $display("[TB] FAIL empty_shadow_r0: got %b expected 0", hazard); else passes++;
    set_idle();
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    fwd_en = 1;
    set_instr(1, 0, 0, 2, 1);
    #1;
    checks++; if (hazard !== 1'b0) $display("[TB] FAIL load_issue: got %b expected 0", hazard); else passes++;
    tick();
    set_instr(2, 4, 1, 3, 0);
    #1;
    checks++; if (hazard !== 1'b1) $display("[TB] FAIL load_use_stall: got %b expected 1", hazard); else passes++;
    tick();
    checks++; if (hazard !== 1'b0) $display("[TB] FAIL load_use_release: got %b expected 0", hazard); else passes++;
    tick();
    set_idle();
    checks++; if (stall_count !== 16'd1) $display("[TB] FAIL load_use_count: got %0d expected 1", stall_count); else passes++;
  endtask

  task automatic test_no_forward_distance();
    for (int k = 0; k < 3; k++) begin
      int seen;
      do_reset();
      fwd_en = 0;
      set_instr(5, 6, 1, 1, 0);
      tick();
      for (int j = 0; j < k; j++) begin
        set_instr(8, 10, 1, 7, 0);
        tick();
      end
      seen = 0;
      set_instr(1, 2, 1, 9, 0);
      for (int c = 0; c < 4; c++) begin
        #1;
        if (hazard === 1'b1) seen++;
        tick();
      end
      checks++;
      if (seen != 2 - k) $display("[TB] FAIL nofwd_gap%0d_stall_cycles: got %0d expected %0d", k, seen, 2 - k);
      else passes++;
    end
    set_idle();
  endtask

  task automatic test_flush_priority();
    do_reset();
    fwd_en = 1;
    set_instr(3, 0, 0, 1, 1);
    tick();
    set_instr(1, 2, 1, 9, 0);
    exe_branch_taken = 1;
    #1;
    checks++; if (flush !== 1'b1) $display("[TB] FAIL flush_with_hazard_flush: got %b expected 1", flush); else passes++;
    checks++; if (hazard !== 1'b0) $display("[TB] FAIL flush_with_hazard_hazard: got %b expected 0", hazard); else passes++;
    tick();
    exe_branch_taken = 0;
    #1;
    checks++; if (flush_count !== 16'd1) $display("[TB] FAIL flush_count: got %0d expected 1", flush_count); else passes++;
    checks++; if (stall_count !== 16'd0) $display("[TB] FAIL flush_stall_unchanged: got %0d expected 0", stall_count); else passes++;
    // The load moved to MEM and EXE is a bubble, so with forwarding nothing stalls.
    checks++; if (hazard !== 1'b0) $display("[TB] FAIL exe_bubble_after_flush: got %b expected 0", hazard); else passes++;
    set_idle();
    tick();
  endtask

  task automatic test_freeze();
    do_reset();
    fwd_en = 0;
    set_instr(5, 6, 1, 1, 0);
    tick();
    set_instr(1, 2, 1, 9, 0);
    #1;
    checks++; if (hazard !== 1'b1) $display("[TB] FAIL freeze_pre: got %b expected 1", hazard); else passes++;
    tick();
    freeze = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (hazard !== 1'b1) $display("[TB] FAIL freeze_hold_%0d: got %b expected 1", c, hazard); else passes++;
      tick();
    end
    checks++; if (stall_count !== 16'd1) $display("[TB] FAIL freeze_count_frozen: got %0d expected 1", stall_count); else passes++;
    freeze = 0;
    #1;
    checks++; if (hazard !== 1'b1) $display("[TB] FAIL freeze_remaining: got %b expected 1", hazard); else passes++;
    tick();
    checks++; if (hazard !== 1'b0) $display("[TB] FAIL freeze_resolved: got %b expected 0", hazard); else passes++;
    checks++; if (stall_count !== 16'd2) $display("[TB] FAIL freeze_count_final: got %0d expected 2", stall_count); else passes++;
    set_idle();
    tick();
  endtask

  task automatic test_saturation_and_reset();
    bit found;
    do_reset();
    fwd_en = 0;
    // ADD R1,R1,R1 repeatedly: each copy waits on the previous one.
    set_instr(1, 1, 1, 1, 0);
    for (int c = 0; c < 60 && m_stall16 < 20; c++) begin
      #1;
      checks++; if (hazard !== exp_hazard()) $display("[TB] FAIL sat_hazard_c%0d: got %b expected %b", c, hazard, exp_hazard()); else passes++;
      tick();
    end
    checks++; if (stall_count4 !== 4'd15) $display("[TB] FAIL sat_count4: got %0d expected 15", stall_count4); else passes++;
    checks++; if (stall_count !== 16'd20) $display("[TB] FAIL sat_count16: got %0d expected 20", stall_count); else passes++;
    found = 0;
    for (int c = 0; c < 5 && !found; c++) begin
      #1;
      if (exp_hazard()) found = 1;
      else tick();
    end
    checks++; if (!found || hazard !== 1'b1) $display("[TB] FAIL sat_stall_before_reset: got %b expected 1", hazard); else passes++;
    checks++; if (stall_count4 !== 4'd15) $display("[TB] FAIL sat_count4_holds: got %0d expected 15", stall_count4); else passes++;
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (hazard !== 1'b0) $display("[TB] FAIL midreset_hazard: got %b expected 0", hazard); else passes++;
    checks++; if (flush !== 1'b0) $display("[TB] FAIL midreset_flush: got %b expected 0", flush); else passes++;
    checks++; if (stall_count !== 16'd0 || stall_count4 !== 4'd0) $display("[TB] FAIL midreset_stall_count: got %0d/%0d expected 0/0", stall_count, stall_count4); else passes++;
    checks++; if (flush_count !== 16'd0) $display("[TB] FAIL midreset_flush_count: got %0d expected 0", flush_count); else passes++;
    set_idle();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst              = ($urandom_range(0, 99) < 2);
      fwd_en           = $urandom_range(0, 1);
      freeze           = ($urandom_range(0, 99) < 15);
      exe_branch_taken = ($urandom_range(0, 99) < 10);
      id_valid         = ($urandom_range(0, 99) < 85);
      id_src1          = 4'($urandom_range(0, 3));
      id_src2          = 4'($urandom_range(0, 3));
      id_dest          = 4'($urandom_range(0, 3));
      id_uses_src1     = ($urandom_range(0, 99) < 85);
      id_two_src       = $urandom_range(0, 1);
      id_wb_en         = ($urandom_range(0, 99) < 75);
      id_mem_read      = ($urandom_range(0, 99) < 35);
      #1;
      checks++; if (hazard !== exp_hazard() || hazard4 !== exp_hazard()) $display("[TB] FAIL rand_hazard_c%0d: got %b/%b expected %b", c, hazard, hazard4, exp_hazard()); else passes++;
      checks++; if (flush !== exp_flush() || flush4 !== exp_flush()) $display("[TB] FAIL rand_flush_c%0d: got %b/%b expected %b", c, flush, flush4, exp_flush()); else passes++;
      checks++; if (stall_count !== 16'(m_stall16) || stall_count4 !== 4'(m_stall4)) $display("[TB] FAIL rand_stall_count_c%0d: got %0d/%0d expected %0d/%0d", c, stall_count, stall_count4, m_stall16, m_stall4); else passes++;
      checks++; if (flush_count !== 16'(m_flush16) || flush_count4 !== 4'(m_flush4)) $display("[TB] FAIL rand_flush_count_c%0d: got %0d/%0d expected %0d/%0d", c, flush_count, flush_count4, m_flush16, m_flush4); else passes++;
      tick();
    end
    rst = 0;
    set_idle();
  endtask

  initial begin
    rst = 1;
    fwd_en = 0;
    set_idle();
    test_reset();
    test_load_use();
    test_no_forward_distance();
    test_flush_priority();
    test_freeze();
    test_saturation_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
